// File: rtl/tl_pkg.sv
// Shared types and constants for the transfer-layer egress path.
// Word width, port count, counter width, arbiter states, quantum decode.
package tl_pkg;

  localparam int DATA_W = 12;
  localparam int NPORT  = 4;
  localparam int CNT_W  = 5;

  // A quantum field of zero selects the longest burst.
  localparam logic [3:0] QZERO = 4'd8;

  typedef enum logic [1:0] {
    WAIT_INIT,
    IDLE,
    ARB,
    BURST
  } arb_st_t;

  function automatic logic [3:0] qdec(input logic [2:0] q);
    return (q == 3'd0) ? QZERO : {1'b0, q};
  endfunction

endpackage

// File: rtl/egress_skid2.sv
// Two-entry {port, data} egress buffer with valid/ready output.
// Ports: in_valid/in_port/in_data push, occ count, valid_out/port_out/data_out/ready_in egress.
module egress_skid2 #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [1:0]        in_port,
  input  logic [DATA_W-1:0] in_data,
  output logic [1:0]        occ,
  output logic              valid_out,
  output logic [1:0]        port_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ready_in
);

  logic [DATA_W+1:0] e0;
  logic [DATA_W+1:0] e1;
  logic [DATA_W+1:0] din;
  logic              hs;

  assign din       = {in_port, in_data};
  assign valid_out = (occ != 2'd0);
  assign hs        = valid_out && ready_in;
  assign port_out  = e0[DATA_W+1:DATA_W];
  assign data_out  = e0[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      occ <= 2'd0;
    end else begin
      case ({in_valid, hs})
        2'b10: begin
          if (occ == 2'd0) e0 <= din;
          else             e1 <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new word lands.
          if (occ == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/egress_rr_arbiter.sv
// Weighted round-robin drain of four class FIFOs onto one egress stream.
// Ports: init/quantum control, fifo_empty/dataOutputPn/popOutPn FIFO side, egress, req/idx counter query, idle.
module egress_rr_arbiter
  import tl_pkg::*;
#(
  parameter int DATA_W = tl_pkg::DATA_W,
  parameter int CNT_W  = tl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        quantum,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] dataOutputP0,
  input  logic [DATA_W-1:0] dataOutputP1,
  input  logic [DATA_W-1:0] dataOutputP2,
  input  logic [DATA_W-1:0] dataOutputP3,
  output logic              popOutP0,
  output logic              popOutP1,
  output logic              popOutP2,
  output logic              popOutP3,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        port_out,
  output logic              valid_out,
  input  logic              ready_in,
  input  logic              req,
  input  logic [1:0]        idx,
  output logic [CNT_W-1:0]  counterOut,
  output logic              counterValid,
  output logic              idle
);

  arb_st_t           st;
  logic [1:0]        last;
  logic [1:0]        gnt;
  logic [1:0]        nxt;
  logic [1:0]        cand;
  logic              found;
  logic [3:0]        bcnt;
  logic [3:0]        qreg;
  logic              infl;
  logic [1:0]        infl_p;
  logic [1:0]        occ;
  logic              hs;
  logic              permit;
  logic              pop;
  logic              allemp;
  logic [3:0]        pops;
  logic [DATA_W-1:0] rdata;
  logic [CNT_W-1:0]  cnt [NPORT];

  assign allemp = &fifo_empty;
  assign hs     = valid_out && ready_in;
  // Room must exist for the popped word once the in-flight one lands.
  assign permit = ({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, hs});
  assign pop    = (st == BURST) && permit && !fifo_empty[gnt] && !init;
  assign pops   = pop ? (4'b0001 << gnt) : 4'b0000;

  assign popOutP0 = pops[0];
  assign popOutP1 = pops[1];
  assign popOutP2 = pops[2];
  assign popOutP3 = pops[3];

  assign idle = (st == IDLE) && (occ == 2'd0) && !infl;

  always_comb begin
    found = 1'b0;
    nxt   = last;
    cand  = last;
    for (int i = 1; i <= NPORT; i++) begin
      cand = last + 2'(i);
      if (!found && !fifo_empty[cand]) begin
        found = 1'b1;
        nxt   = cand;
      end
    end
  end

  always_comb begin
    rdata = dataOutputP0;
    unique case (infl_p)
      2'd1:    rdata = dataOutputP1;
      2'd2:    rdata = dataOutputP2;
      2'd3:    rdata = dataOutputP3;
      default: rdata = dataOutputP0;
    endcase
  end

  egress_skid2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (infl),
    .in_port  (infl_p),
    .in_data  (rdata),
    .occ      (occ),
    .valid_out(valid_out),
    .port_out (port_out),
    .data_out (data_out),
    .ready_in (ready_in)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st     <= WAIT_INIT;
      last   <= 2'd3;
      gnt    <= 2'd0;
      bcnt   <= 4'd0;
      qreg   <= 4'd1;
      infl   <= 1'b0;
      infl_p <= 2'd0;
    end else begin
      infl <= pop;
      if (pop) infl_p <= gnt;
      if (init) begin
        qreg <= qdec(quantum);
        bcnt <= 4'd0;
        st   <= (st == WAIT_INIT) ? IDLE : ARB;
      end else begin
        unique case (st)
          WAIT_INIT: ;
          IDLE: if (!allemp) st <= ARB;
          ARB: begin
            if (found) begin
              gnt  <= nxt;
              last <= nxt;
              bcnt <= 4'd0;
              st   <= BURST;
            end else begin
              st <= IDLE;
            end
          end
          BURST: begin
            if (permit) begin
              if (fifo_empty[gnt]) begin
                st <= allemp ? IDLE : ARB;
              end else begin
                bcnt <= bcnt + 4'd1;
                if (bcnt + 4'd1 == qreg) st <= ARB;
              end
            end
          end
          default: st <= WAIT_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPORT; i++) cnt[i] <= '0;
      counterOut   <= '0;
      counterValid <= 1'b0;
    end else begin
      counterValid <= req;
      if (req) counterOut <= cnt[idx];
      if (init) begin
        for (int i = 0; i < NPORT; i++) cnt[i] <= '0;
      end else if (hs) begin
        cnt[port_out] <= cnt[port_out] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_egress_rr_arbiter.sv
// Bench for egress_rr_arbiter: FIFO model, egress scoreboard,
// vector table of burst scenarios and hand-written corner sequences.
module tb_egress_rr_arbiter;

  localparam int DW = 12;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init;
  logic [2:0]    quantum;
  logic [3:0]    emp = 4'hF;
  logic [DW-1:0] dout [4] = '{default: '0};
  logic          p0, p1, p2, p3;
  logic [DW-1:0] data_out;
  logic [1:0]    port_out;
  logic          valid_out;
  logic          ready_in;
  logic          req;
  logic [1:0]    idx;
  logic [CW-1:0] counterOut;
  logic          counterValid;
  logic          idle;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wseq = 0;
  int hs_count = 0;
  int first_valid = -1;

  logic [DW-1:0]   fq [4][$];
  logic [DW+1:0]   exp_q [$];
  int              pop_cyc [$];
  int              pop_port [$];

  logic            pv_valid = 1'b0;
  logic            pv_ready = 1'b0;
  logic [DW+1:0]   pv_word = '0;

  typedef struct {
    logic [2:0] q;
    int         port;
    int         n;
    int         exp_pops;
    int         exp_runs;
  } vec_t;

  vec_t vt [6];

  egress_rr_arbiter dut (
    .clk         (clk),
    .reset       (rst_n),
    .init        (init),
    .quantum     (quantum),
    .fifo_empty  (emp),
    .dataOutputP0(dout[0]),
    .dataOutputP1(dout[1]),
    .dataOutputP2(dout[2]),
    .dataOutputP3(dout[3]),
    .popOutP0    (p0),
    .popOutP1    (p1),
    .popOutP2    (p2),
    .popOutP3    (p3),
    .data_out    (data_out),
    .port_out    (port_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .req         (req),
    .idx         (idx),
    .counterOut  (counterOut),
    .counterValid(counterValid),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] mkw(input int p, input int k);
    return DW'(p * 1024 + (k % 1024));
  endfunction

  // FIFO model: data appears the cycle after the pop, empty flag one cycle late.
  always @(posedge clk) begin
    logic [3:0] pv;
    pv = {p3, p2, p1, p0};
    if (pv != 4'd0) begin
      chk("pop onehot", $countones(pv), 1);
      for (int n = 0; n < 4; n++) begin
        if (pv[n]) begin
          chk("pop nonempty", int'(fq[n].size() > 0), 1);
          if (fq[n].size() > 0) dout[n] <= fq[n].pop_front();
          pop_cyc.push_back(cyc);
          pop_port.push_back(n);
        end
      end
    end
    for (int n = 0; n < 4; n++) emp[n] <= (fq[n].size() == 0);
    cyc++;
  end

  // Egress monitor and scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_valid && !pv_ready)
        chk("hold", int'({valid_out, port_out, data_out}), int'({1'b1, pv_word}));
      if (valid_out && first_valid < 0) first_valid = cyc;
      if (valid_out && ready_in) begin
        hs_count++;
        if (exp_q.size() == 0) chk("unexpected word", int'({port_out, data_out}), -1);
        else chk("egress word", int'({port_out, data_out}), int'(exp_q.pop_front()));
      end
    end
    pv_valid = valid_out && rst_n;
    pv_ready = ready_in;
    pv_word  = {port_out, data_out};
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int p, input int n, input bit sb);
    logic [DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = mkw(p, wseq);
      wseq++;
      fq[p].push_back(w);
      if (sb) exp_q.push_back({2'(p), w});
    end
  endtask

  task automatic clr();
    pop_cyc.delete();
    pop_port.delete();
    hs_count = 0;
    first_valid = -1;
  endtask

  task automatic do_init(input logic [2:0] q);
    init = 1'b1;
    quantum = q;
    step();
    init = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, " pops"}, int'({p3, p2, p1, p0}), 0);
    chk({tag, " valid_out"}, int'(valid_out), 0);
    chk({tag, " data_out"}, int'(data_out), 0);
    chk({tag, " port_out"}, int'(port_out), 0);
    chk({tag, " counterOut"}, int'(counterOut), 0);
    chk({tag, " counterValid"}, int'(counterValid), 0);
    chk({tag, " idle"}, int'(idle), 0);
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int k;
    k = 0;
    while (!(idle && exp_q.size() == 0) && k < maxc) begin
      step();
      k++;
    end
    chk(name, int'(idle), 1);
    chk({name, " sb empty"}, exp_q.size(), 0);
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_rst(tag);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [DW+1:0] tail0, tail1;
    int k, n3, runs;

    rst_n = 1'b0;
    init = 1'b0;
    quantum = 3'd0;
    ready_in = 1'b1;
    req = 1'b0;
    idx = 2'd0;

    vt[0] = '{3'd1, 1, 3, 3, 3};
    vt[1] = '{3'd3, 2, 7, 7, 3};
    vt[2] = '{3'd0, 0, 9, 9, 2};
    vt[3] = '{3'd4, 3, 4, 4, 1};
    vt[4] = '{3'd5, 1, 5, 5, 1};
    vt[5] = '{3'd7, 2, 16, 16, 3};

    step(2);
    chk_rst("reset");
    rst_n = 1'b1;
    step();

    // Basic burst with quantum 2; no pops before init.
    clr();
    push(0, 3, 1);
    step(3);
    chk("no pop before init", pop_cyc.size(), 0);
    do_init(3'd2);
    wait_idle("t1 idle", 60);
    chk("t1 pops", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t1 pop port", pop_port[i], 0);
      chk("t1 gap01", pop_cyc[1] - pop_cyc[0], 1);
      chk("t1 gap12", pop_cyc[2] - pop_cyc[1], 2);
      chk("t1 latency", first_valid - pop_cyc[0], 2);
    end
    chk("t1 words", hs_count, 3);

    // Quantum 1 across all ports from a fresh pointer.
    apply_reset("t2 reset");
    do_init(3'd1);
    clr();
    for (int w = 0; w < 2; w++)
      for (int p = 0; p < 4; p++) push(p, 1, 1);
    wait_idle("t2 idle", 80);
    chk("t2 pops", pop_cyc.size(), 8);
    if (pop_cyc.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t2 order", pop_port[i], i % 4);
      for (int i = 0; i < 7; i++) chk("t2 bubble", pop_cyc[i+1] - pop_cyc[i], 2);
    end

    // Quantum 0 means 8; P1 arrives once P2 is granted.
    do_init(3'd0);
    clr();
    push(2, 10, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back({2'd2, fq[2][i]});
    tail0 = {2'd2, fq[2][8]};
    tail1 = {2'd2, fq[2][9]};
    k = 0;
    while (pop_cyc.size() == 0 && k < 50) begin
      step();
      k++;
    end
    chk("t3 first pop seen", int'(pop_cyc.size() > 0), 1);
    push(1, 1, 1);
    exp_q.push_back(tail0);
    exp_q.push_back(tail1);
    wait_idle("t3 idle", 100);
    chk("t3 words", hs_count, 11);

    // Backpressure mid-burst.
    do_init(3'd0);
    clr();
    push(1, 8, 1);
    k = 0;
    while (pop_cyc.size() < 2 && k < 50) begin
      step();
      k++;
    end
    ready_in = 1'b0;
    step(3);
    n3 = pop_cyc.size();
    step(3);
    chk("t4 no pops stalled", pop_cyc.size(), n3);
    chk("t4 buffered", pop_cyc.size() - hs_count, 2);
    chk("t4 valid held", int'(valid_out), 1);
    ready_in = 1'b1;
    wait_idle("t4 idle", 100);
    chk("t4 words", hs_count, 8);

    // Counter wrap and read timing.
    do_init(3'd0);
    clr();
    push(3, 33, 1);
    wait_idle("t5 idle", 200);
    req = 1'b1;
    idx = 2'd3;
    step();
    req = 1'b0;
    chk("t5 cnt3 wrap", int'(counterOut), 1);
    chk("t5 cv pulse", int'(counterValid), 1);
    step();
    chk("t5 cv low", int'(counterValid), 0);
    req = 1'b1;
    idx = 2'd2;
    step();
    req = 1'b0;
    chk("t5 cnt2", int'(counterOut), 0);
    ready_in = 1'b0;
    push(3, 1, 1);
    k = 0;
    while (!valid_out && k < 20) begin
      step();
      k++;
    end
    chk("t5 word waiting", int'(valid_out), 1);
    ready_in = 1'b1;
    req = 1'b1;
    idx = 2'd3;
    step();
    chk("t5 old value", int'(counterOut), 1);
    step();
    req = 1'b0;
    chk("t5 new value", int'(counterOut), 2);
    wait_idle("t5 drain", 20);

    // Table of burst lengths.
    for (int v = 0; v < 6; v++) begin
      do_init(vt[v].q);
      clr();
      push(vt[v].port, vt[v].n, 1);
      wait_idle("vec idle", 150);
      chk("vec pops", pop_cyc.size(), vt[v].exp_pops);
      runs = 0;
      for (int i = 0; i < pop_cyc.size(); i++)
        if (i == 0 || pop_cyc[i] != pop_cyc[i-1] + 1) runs++;
      chk("vec runs", runs, vt[v].exp_runs);
      chk("vec words", hs_count, vt[v].n);
    end

    // Reset with two words buffered.
    do_init(3'd0);
    clr();
    ready_in = 1'b0;
    push(0, 6, 0);
    step(8);
    chk("t6 pops before reset", pop_cyc.size(), 2);
    chk("t6 valid before reset", int'(valid_out), 1);
    rst_n = 1'b0;
    #1;
    chk_rst("t6 reset");
    step();
    rst_n = 1'b1;
    ready_in = 1'b1;
    step(5);
    chk("t6 no pops after reset", pop_cyc.size(), 2);
    chk("t6 valid after reset", int'(valid_out), 0);
    chk("t6 no words", hs_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/egress_rr_arbiter.md
# egress_rr_arbiter

- Drains the four per-class output FIFOs (P0–P3) of the transaction-layer transfer stage onto a single 12-bit egress stream with a valid/ready handshake.
- Uses weighted round-robin: each visit to a port may pop up to `quantum` words in a row before the arbiter moves on.
- Keeps a 5-bit delivered-word counter per port, readable through a req/idx query port.
- Sits directly downstream of the transfer layer and generates that block's `popOutP0..3`.

## Interface
Parameters:
- DATA_W, 12, word width (matches transfer-layer FIFO data)
- CNT_W, 5, per-port delivered-word counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- init  in  1  one-cycle pulse: latch `quantum`, clear counters, enable arbitration
- quantum  in  3  words per burst; 0 means 8
- fifo_empty  in  4  empty flags of P0..P3 (bit n = Pn)
- dataOutputP0..P3  in  DATA_W each  FIFO read data; valid the cycle after the pop
- popOutP0..P3  out  1 each  one-cycle pop strobes to the FIFOs
- data_out  out  DATA_W  egress word
- port_out  out  2  source port of `data_out`
- valid_out  out  1  `data_out` and `port_out` are valid
- ready_in  in  1  downstream accepts when valid_out && ready_in
- req  in  1  counter read request
- idx  in  2  port to read
- counterOut  out  CNT_W  requested counter value
- counterValid  out  1  counterOut valid, one-cycle pulse
- idle  out  1  state is IDLE, buffer empty, no pop in flight

## Operation
- State machine: WAIT_INIT → (init) → IDLE ⇄ ARB → BURST → ARB/IDLE.
  - WAIT_INIT: no pops; `idle`=0.
  - IDLE: entered whenever all `fifo_empty`=1. Leaves for ARB when any port is non-empty.
  - ARB: one cycle, no pop. Grant the first non-empty port scanning last+1, last+2, … mod 4. `last` resets to 3, so the first grant is P0 when P0 is non-empty.
  - BURST: pop the granted port each cycle the pop is permitted. Exit to ARB (or IDLE if all ports are empty) when:
    - `quantum` words have been popped, or
    - the granted port is empty when a pop is permitted (that cycle does not pop).
- Pop permission: a pop is permitted when (buffer occupancy + pop in flight − egress handshake this cycle) < 2, where the egress handshake is valid_out && ready_in.
- Buffering: a 2-entry output buffer captures {port, data} the cycle after a pop. It never overflows and never drops a word.
- At most one popOutPn is high in any cycle. No pop is issued to a port whose fifo_empty=1.
- Counters: cnt[port] increments on each egress handshake and wraps 31→0.
- Counter read: req in cycle t → cycle t+1 counterOut=cnt[idx] (pre-increment value if an increment coincides) and counterValid=1.
- init mid-operation:
  - counters clear and quantum reloads;
  - the buffer and any in-flight word are preserved and delivered;
  - the FSM goes to ARB.
- Reset mid-operation: all state clears and buffered words are discarded; the FSM returns to WAIT_INIT.

## Timing
- Reset values: all popOutPn=0, valid_out=0, data_out=0, port_out=0, counterOut=0, counterValid=0, idle=0, cnt=0, quantum register=1.
- Pop at cycle t → word in buffer → valid_out=1 at t+2. Latency is 2 cycles with ready_in=1.
- Sustained throughput: 1 word/cycle within a burst, plus 1 bubble cycle per grant change (ARB).
- valid_out, data_out and port_out are held stable while valid_out && !ready_in.
- With ready_in=0 and the buffer full, no pops are issued. Arbitration state and the burst count freeze.
- The FIFO empty flag reflects a pop from the next cycle onward. This allows back-to-back pops until the flag rises.

## Structure
- Shared package `tl_pkg`:
  - DATA_W, NPORT=4, CNT_W;
  - FSM state enum (WAIT_INIT, IDLE, ARB, BURST);
  - the quantum-decode constant (0→8).
- One sub-module, `egress_skid2`: the 2-entry {port, data} buffer with occupancy output and valid/ready egress.
- Arbiter FSM, round-robin pointer, burst counter and counters live in the top module.

## Test plan
- Reset, init with quantum=2, push 3 words to P0 only, ready_in=1 → pops P0,P0,(ARB),P0 → 3 words on port_out=0, first valid_out 2 cycles after the first pop; then idle=1.
- quantum=1, 2 words in each of P0..P3 → port_out sequence 0,1,2,3,0,1,2,3 with one bubble between grants.
- quantum=0, 10 words in P2 and 1 in P1 → 8 from P2, then 1 from P1, then 2 from P2.
- ready_in=0 for 6 cycles during a burst → exactly 2 words buffered, no further pops, data_out stable; on release, no loss or duplication.
- 33 words through P3, then req with idx=3 → counterOut=1 (wrap), counterValid a one-cycle pulse; req in the same cycle as an increment returns the old value.
- Assert reset mid-burst with 2 words buffered → outputs return to reset values immediately; no pops until the next init.
